unit1_issue_queue: RTL
======================

# unit1_issue_queue

Reservation-station style issue queue in front of unit1, the branch/ALU execution unit. It holds up to DEPTH decoded ops, captures missing source operands from the ALU and FPU result broadcasts, and issues at most one ready op per cycle to unit1 as a registered bundle. It flushes on a branch hazard and keeps control-flow ops in program order.

## Interface
- DEPTH, 4, number of entries (2..8)
- TAG_W, 6, register tag width; tag 0 = no register
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  dispatch offers an op
- in_ready  out  1  queue accepts the op this cycle
- in_pc  in  14  op PC
- in_ope  in  6  opcode; 0 = NOP, never enqueued
- in_ds_tag, in_dt_tag  in  TAG_W  source tags
- in_ds_rdy, in_dt_rdy  in  1  source value already valid
- in_ds_val, in_dt_val  in  32  source values when ready
- in_dd  in  TAG_W  destination tag
- in_imm  in  16  immediate
- in_opr  in  5  compare operand
- in_ctrl  in  4  control bits (bit0 = predicted taken)
- alu_addr, fpu_addr  in  TAG_W  broadcast tags; 0 = none
- alu_dd_val, fpu_dd_val  in  32  broadcast values
- flush  in  1  unit1 b_is_hazard
- out_pc, out_ope, out_ds_val, out_dt_val, out_dd, out_imm, out_opr, out_ctrl  out  widths as inputs  registered issue bundle to unit1; out_ope = 0 means no issue
- count  out  4  valid entries

## Operation
- Entries are compacting: index 0 is oldest. On a dequeue, younger entries shift down one slot. A new entry is written at slot count, or count-1 if one issued the same cycle.
- in_ready = (count < DEPTH). This uses the registered count, with no same-cycle dequeue credit.
- Enqueue happens when in_valid & in_ready & in_ope != 0 & ~flush.
- Source readiness: a source is ready if its rdy flag is set, or its tag = 0.
- Wakeup: every cycle, each not-ready source with tag T matches alu_addr == T (T != 0) or fpu_addr == T. On a match, the source captures the value and becomes ready. If both buses match the same tag, ALU has priority.
- Wakeup also applies to the op being enqueued in the same cycle.
- Control op: ope[1:0] == 2'b10. It is eligible only when in slot 0.
- Non-control op: eligible when both sources are ready.
- Select: the lowest-index eligible entry is issued. That entry's fields are loaded into the out_* register and the entry is removed.
- With no eligible entry, out_ope <= 0 and the other out_* fields hold.
- Flush: on the next edge, all entries are invalid, count = 0, and out_ope = 0. In the flush cycle nothing is enqueued or issued.

## Timing
- Reset: count = 0, all entries invalid, out_ope = 0. All other out_* fields = 0. in_ready = 1 in the cycle after reset.
- Enqueue-to-issue latency, op with ready sources on an empty queue: written at edge N, issued to out_* at edge N+1.
- Wakeup at cycle N (broadcast present during cycle N):
  - the value is latched at edge N+1;
  - selection timing depends on the macro (see Configuration).
- Simultaneous issue and enqueue with count = DEPTH is impossible, because in_ready = 0.
- With count = DEPTH-1, an enqueue and an issue in the same cycle leave count = DEPTH-1.
- flush together with rst: reset wins (same result).
- flush mid-shift: the shift is discarded.
- The queue never stalls on unit1. unit1 accepts one op per cycle.

## Configuration
- UNIT1_IQ_WAKEUP_BYPASS_EN.
  - Defined: select uses readiness merged with the current-cycle wakeup match. A source woken at cycle N can issue at edge N+1, and the issued operand value comes straight from the broadcast bus.
  - Undefined: select uses registered readiness only. An entry woken at cycle N issues no earlier than edge N+2.

## Test plan
- Reset with in_valid = 1 → count = 0, out_ope = 0, in_ready = 1 after the reset edge.
- Enqueue ADD (ope 001100, ds/dt ready, 5 and 7, dd 3) into an empty queue → one cycle later out_ope = 001100, out_ds_val = 5, out_dt_val = 7, out_dd = 3; count returns to 0.
- Enqueue ADD with ds_tag 9 not ready; two cycles later alu_addr = 9, alu_dd_val = 0x1234 → with BYPASS_EN, issue at the next edge with out_ds_val = 0x1234; without it, one cycle later.
- Enqueue blocked op A (tag 9), then BEQ (010010, ready), then ready ADD → ADD issues first; BEQ waits until A leaves slot 0; then BEQ issues.
- Fill DEPTH = 4 entries, all blocked → in_ready = 0, count = 4. A fifth in_valid is not accepted. Wake one entry → in_ready returns to 1 after it issues.
- Queue holding 3 entries, flush = 1 with in_valid = 1 → next cycle count = 0, out_ope = 0, and the offered op is not enqueued.

Source files
------------

// File: rtl/unit1_issue_queue.sv
// unit1_issue_queue: compacting reservation-station issue queue feeding unit1 one op per cycle.
// Define UNIT1_IQ_WAKEUP_BYPASS_EN to let select see same-cycle broadcast wakeups.
module unit1_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [13:0]      in_pc,
  input  logic [5:0]       in_ope,
  input  logic [TAG_W-1:0] in_ds_tag,
  input  logic [TAG_W-1:0] in_dt_tag,
  input  logic             in_ds_rdy,
  input  logic             in_dt_rdy,
  input  logic [31:0]      in_ds_val,
  input  logic [31:0]      in_dt_val,
  input  logic [TAG_W-1:0] in_dd,
  input  logic [15:0]      in_imm,
  input  logic [4:0]       in_opr,
  input  logic [3:0]       in_ctrl,
  input  logic [TAG_W-1:0] alu_addr,
  input  logic [TAG_W-1:0] fpu_addr,
  input  logic [31:0]      alu_dd_val,
  input  logic [31:0]      fpu_dd_val,
  input  logic             flush,
  output logic [13:0]      out_pc,
  output logic [5:0]       out_ope,
  output logic [31:0]      out_ds_val,
  output logic [31:0]      out_dt_val,
  output logic [TAG_W-1:0] out_dd,
  output logic [15:0]      out_imm,
  output logic [4:0]       out_opr,
  output logic [3:0]       out_ctrl,
  output logic [3:0]       count
);
  typedef struct packed {
    logic [13:0]      pc;
    logic [5:0]       ope;
    logic [31:0]      ds_val;
    logic [31:0]      dt_val;
    logic [TAG_W-1:0] dd;
    logic [15:0]      imm;
    logic [4:0]       opr;
    logic [3:0]       ctrl;
  } bundle_t;

  typedef struct packed {
    logic [TAG_W-1:0] ds_tag;
    logic [TAG_W-1:0] dt_tag;
    logic             ds_rdy;
    logic             dt_rdy;
    bundle_t          b;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  entry_t           woke  [DEPTH];
  entry_t           new_e, new_w;
  bundle_t          out_q, out_d;
  logic [3:0]       count_q, count_d, sel, wr;
  logic [DEPTH-1:0] elig;
  logic             issue, enq;

  // ALU wins when both buses carry the same tag
  function automatic entry_t wake(input entry_t e, input logic [TAG_W-1:0] aa, input logic [TAG_W-1:0] fa,
                                  input logic [31:0] av, input logic [31:0] fv);
    entry_t r;
    logic   ds_a, ds_f, dt_a, dt_f;
    ds_a = !e.ds_rdy && e.ds_tag != '0 && e.ds_tag == aa;
    ds_f = !e.ds_rdy && e.ds_tag != '0 && e.ds_tag == fa;
    dt_a = !e.dt_rdy && e.dt_tag != '0 && e.dt_tag == aa;
    dt_f = !e.dt_rdy && e.dt_tag != '0 && e.dt_tag == fa;
    r = e;
    r.ds_rdy = e.ds_rdy | ds_a | ds_f;
    r.dt_rdy = e.dt_rdy | dt_a | dt_f;
    r.b.ds_val = ds_a ? av : ds_f ? fv : e.b.ds_val;
    r.b.dt_val = dt_a ? av : dt_f ? fv : e.b.dt_val;
    return r;
  endfunction

  assign new_e = '{ds_tag: in_ds_tag, dt_tag: in_dt_tag,
                   ds_rdy: in_ds_rdy | (in_ds_tag == '0), dt_rdy: in_dt_rdy | (in_dt_tag == '0),
                   b: '{pc: in_pc, ope: in_ope, ds_val: in_ds_val, dt_val: in_dt_val,
                        dd: in_dd, imm: in_imm, opr: in_opr, ctrl: in_ctrl}};

  assign in_ready = count_q < 4'(DEPTH);

  always_comb begin
    new_w = wake(new_e, alu_addr, fpu_addr, alu_dd_val, fpu_dd_val);
    for (int i = 0; i < DEPTH; i++) begin
      woke[i] = wake(ent_q[i], alu_addr, fpu_addr, alu_dd_val, fpu_dd_val);
`ifdef UNIT1_IQ_WAKEUP_BYPASS_EN
      elig[i] = 4'(i) < count_q && woke[i].ds_rdy && woke[i].dt_rdy && (ent_q[i].b.ope[1:0] != 2'b10 || i == 0);
`else
      elig[i] = 4'(i) < count_q && ent_q[i].ds_rdy && ent_q[i].dt_rdy && (ent_q[i].b.ope[1:0] != 2'b10 || i == 0);
`endif
    end
    sel = '0;
    for (int i = DEPTH - 1; i >= 0; i--) if (elig[i]) sel = 4'(i);
    issue = |elig & ~flush;
    enq = in_valid & in_ready & (in_ope != '0) & ~flush;
    wr = count_q - {3'b0, issue};
    out_d = out_q;
    out_d.ope = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = (issue && 4'(i) >= sel) ? woke[(i < DEPTH - 1) ? i + 1 : i] : woke[i];
      if (enq && 4'(i) == wr) ent_d[i] = new_w;
      if (issue && 4'(i) == sel) out_d = woke[i].b;
    end
    count_d = flush ? '0 : count_q - {3'b0, issue} + {3'b0, enq};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      out_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      count_q <= count_d;
      out_q <= out_d;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

  assign out_pc     = out_q.pc;
  assign out_ope    = out_q.ope;
  assign out_ds_val = out_q.ds_val;
  assign out_dt_val = out_q.dt_val;
  assign out_dd     = out_q.dd;
  assign out_imm    = out_q.imm;
  assign out_opr    = out_q.opr;
  assign out_ctrl   = out_q.ctrl;
  assign count      = count_q;
endmodule
